// File: rtl/write_burst_len_gen.sv
// Write-side burst planner: issues full or tail burst requests as the write FIFO fills.
// Optional frame_cnt output enabled by defining WR_FRAME_CNT_EN.
module write_burst_len_gen #(
    parameter int unsigned NOR_BURST_LEN = 200,
    parameter string       MODE          = "ONCE",
    parameter int unsigned AXI_DSIZE     = 256,
    parameter int unsigned DSIZE         = 24,
    parameter int unsigned LSIZE         = 9
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [15:0]      vactive,
    input  logic [15:0]      hactive,
    input  logic             fsync,
    input  logic [15:0]      fifo_count,
    output logic             burst_req,
    output logic [LSIZE-1:0] burst_len,
    input  logic             burst_ack,
    input  logic             burst_done,
    output logic             tail_status,
    output logic             frame_done
`ifdef WR_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam bit          LINE_MODE = (MODE == "LINE");
    localparam int unsigned SHIFT     = $clog2(AXI_DSIZE);
    localparam int unsigned PROD_W    = 48;
    localparam logic [31:0] NOR_LEN   = 32'(NOR_BURST_LEN);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        REQ       = 2'd2,
        BUSY      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        all_bits_q;
    logic [31:0]        total_q;
    logic [31:0]        remaining_q, remaining_d;
    logic [31:0]        rem_sub;
    logic [LSIZE-1:0]   burst_len_q, burst_len_d;
    logic               burst_req_q, burst_req_d;
    logic               tail_q, tail_d;
    logic               frame_done_q, frame_done_d;
    logic               done_d1_q;
    logic               done_rise;

    // Words per transfer, rounded up to whole AXI words; two register stages.
    always_ff @(posedge clock) begin
        if (rst) begin
            all_bits_q <= '0;
            total_q    <= '0;
        end else begin
            all_bits_q <= LINE_MODE ? 32'(hactive) : 32'(vactive) * 32'(hactive);
            total_q    <= 32'((PROD_W'(all_bits_q) * PROD_W'(DSIZE)
                               + PROD_W'(AXI_DSIZE - 1)) >> SHIFT);
        end
    end

    assign done_rise = burst_done & ~done_d1_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            burst_len_q  <= '0;
            burst_req_q  <= 1'b0;
            tail_q       <= 1'b0;
            frame_done_q <= 1'b0;
            done_d1_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            burst_len_q  <= burst_len_d;
            burst_req_q  <= burst_req_d;
            tail_q       <= tail_d;
            frame_done_q <= frame_done_d;
            done_d1_q    <= burst_done;
        end
    end

    // Next state; fsync overrides everything, including a same-cycle completion.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        burst_len_d  = burst_len_q;
        frame_done_d = 1'b0;
        rem_sub      = remaining_q - 32'(burst_len_q);
        if (fsync) begin
            remaining_d = total_q;
            state_d     = (total_q == '0) ? IDLE : WAIT_DATA;
        end else begin
            case (state_q)
                IDLE: ;
                WAIT_DATA: begin
                    if (remaining_q >= NOR_LEN && 32'(fifo_count) >= NOR_LEN) begin
                        burst_len_d = LSIZE'(NOR_BURST_LEN);
                        state_d     = REQ;
                    end else if (remaining_q != '0 && remaining_q < NOR_LEN &&
                                 32'(fifo_count) >= remaining_q) begin
                        burst_len_d = LSIZE'(remaining_q);
                        state_d     = REQ;
                    end
                end
                REQ: begin
                    if (burst_ack && burst_req_q) begin
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (done_rise) begin
                        remaining_d = rem_sub;
                        if (rem_sub == '0) begin
                            frame_done_d = 1'b1;
                            if (LINE_MODE) begin
                                remaining_d = total_q;
                                state_d     = WAIT_DATA;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            state_d = WAIT_DATA;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        burst_req_d = (state_d == REQ);
        tail_d      = (remaining_d != '0) && (remaining_d < NOR_LEN);
    end

    assign burst_req   = burst_req_q;
    assign burst_len   = burst_len_q;
    assign tail_status = tail_q;
    assign frame_done  = frame_done_q;

`ifdef WR_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (frame_done_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_write_burst_len_gen.sv
// Bench for write_burst_len_gen: ONCE and LINE instances, scoreboard of expected bursts.
module tb_write_burst_len_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] vactive, hactive, fifo_count;
    logic        fsync, burst_ack, burst_done;
    logic        o_req, o_tail, o_fd;
    logic [8:0]  o_len;
    logic        l_req, l_tail, l_fd;
    logic [8:0]  l_len;
`ifdef WR_FRAME_CNT_EN
    logic [15:0] o_fcnt, l_fcnt;
`endif

    typedef struct packed {
        logic [8:0] len;
        logic       tail;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   fd_o  = 0;
    int   fd_l  = 0;

    always #5 clk = ~clk;

    write_burst_len_gen #(.NOR_BURST_LEN(16), .MODE("ONCE"), .AXI_DSIZE(256),
                          .DSIZE(24), .LSIZE(9)) dut_o (
        .clock(clk), .rst(rst), .vactive(vactive), .hactive(hactive),
        .fsync(fsync), .fifo_count(fifo_count), .burst_req(o_req),
        .burst_len(o_len), .burst_ack(burst_ack), .burst_done(burst_done),
        .tail_status(o_tail), .frame_done(o_fd)
`ifdef WR_FRAME_CNT_EN
        , .frame_cnt(o_fcnt)
`endif
    );

    write_burst_len_gen #(.NOR_BURST_LEN(16), .MODE("LINE"), .AXI_DSIZE(256),
                          .DSIZE(24), .LSIZE(9)) dut_l (
        .clock(clk), .rst(rst), .vactive(vactive), .hactive(hactive),
        .fsync(fsync), .fifo_count(fifo_count), .burst_req(l_req),
        .burst_len(l_len), .burst_ack(burst_ack), .burst_done(burst_done),
        .tail_status(l_tail), .frame_done(l_fd)
`ifdef WR_FRAME_CNT_EN
        , .frame_cnt(l_fcnt)
`endif
    );

    always @(negedge clk) begin
        if (o_fd) fd_o++;
        if (l_fd) fd_l++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        fsync      = 1'b0;
        burst_ack  = 1'b0;
        burst_done = 1'b0;
        fifo_count = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_geom(input logic [15:0] v, input logic [15:0] h);
        vactive = v;
        hactive = h;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_fsync();
        fsync = 1'b1;
        @(negedge clk);
        fsync = 1'b0;
    endtask

    task automatic expect_req(input bit line_sel);
        int   waited = 0;
        exp_t e;
        while (!(line_sel ? l_req : o_req) && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        chk("req_seen", 32'(line_sel ? l_req : o_req), 32'd1);
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk("len", 32'(line_sel ? l_len : o_len), 32'(e.len));
        chk("tail", 32'(line_sel ? l_tail : o_tail), 32'(e.tail));
    endtask

    task automatic serve(input bit line_sel, input int done_cycles);
        expect_req(line_sel);
        @(negedge clk);
        chk("req_hold", 32'(line_sel ? l_req : o_req), 32'd1);
        burst_ack = 1'b1;
        @(negedge clk);
        burst_ack = 1'b0;
        chk("req_drop", 32'(line_sel ? l_req : o_req), 32'd0);
        repeat (2) @(negedge clk);
        burst_done = 1'b1;
        repeat (done_cycles) @(negedge clk);
        burst_done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  fd0;
        bit  seen;
        vactive = '0;
        hactive = '0;
        do_reset();

        // Reset values
        chk("rst_req_o", 32'(o_req), 0);
        chk("rst_len_o", 32'(o_len), 0);
        chk("rst_tail_o", 32'(o_tail), 0);
        chk("rst_fd_o", 32'(o_fd), 0);
        chk("rst_req_l", 32'(l_req), 0);
        chk("rst_state_o", 32'(dut_o.state_q), 0);

        // ONCE frame: 64x4 pixels -> 24 words -> 16 + tail 8
        set_geom(16'd4, 16'd64);
        fifo_count = 16'd32;
        sb_q.push_back('{len: 9'd16, tail: 1'b0});
        sb_q.push_back('{len: 9'd8, tail: 1'b1});
        fd0 = fd_o;
        pulse_fsync();
        chk("once_rem_fsync", dut_o.remaining_q, 32'd24);
        serve(1'b0, 1);
        serve(1'b0, 1);
        chk("once_fd_count", 32'(fd_o - fd0), 32'd1);
        chk("once_state_idle", 32'(dut_o.state_q), 32'd0);
        chk("once_rem_zero", dut_o.remaining_q, 32'd0);

        // LINE mode: 100 pixels -> 10 words, tail-only bursts repeating
        do_reset();
        set_geom(16'd4, 16'd100);
        fifo_count = 16'd10;
        for (int i = 0; i < 3; i++) sb_q.push_back('{len: 9'd10, tail: 1'b1});
        pulse_fsync();
        for (int i = 0; i < 3; i++) begin
            fd0 = fd_l;
            serve(1'b1, 1);
            chk("line_fd", 32'(fd_l - fd0), 32'd1);
            chk("line_reload", dut_l.remaining_q, 32'd10);
        end

        // FIFO threshold: 15 words never enough for a full burst
        do_reset();
        set_geom(16'd4, 16'd64);
        fifo_count = 16'd15;
        pulse_fsync();
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= o_req;
        end
        chk("no_req_at_15", 32'(seen), 32'd0);
        sb_q.push_back('{len: 9'd16, tail: 1'b0});
        fifo_count = 16'd16;
        @(negedge clk);
        chk("req_latency", 32'(o_req), 32'd1);
        expect_req(1'b0);

        // fsync in BUSY with a simultaneous burst_done edge
        do_reset();
        set_geom(16'd4, 16'd64);
        fifo_count = 16'd32;
        sb_q.push_back('{len: 9'd16, tail: 1'b0});
        pulse_fsync();
        expect_req(1'b0);
        burst_ack = 1'b1;
        @(negedge clk);
        burst_ack = 1'b0;
        chk("busy_before_fsync", 32'(dut_o.state_q), 32'd3);
        fd0 = fd_o;
        fifo_count = 16'd0;
        burst_done = 1'b1;
        fsync = 1'b1;
        @(negedge clk);
        fsync = 1'b0;
        chk("fsync_busy_rem", dut_o.remaining_q, 32'd24);
        chk("fsync_busy_state", 32'(dut_o.state_q), 32'd1);
        chk("fsync_busy_req", 32'(o_req), 32'd0);
        @(negedge clk);
        burst_done = 1'b0;
        @(negedge clk);
        chk("fsync_busy_nofd", 32'(fd_o - fd0), 32'd0);
        chk("fsync_busy_rem2", dut_o.remaining_q, 32'd24);

        // burst_done level held 5 cycles counts once
        do_reset();
        set_geom(16'd4, 16'd64);
        fifo_count = 16'd32;
        sb_q.push_back('{len: 9'd16, tail: 1'b0});
        pulse_fsync();
        serve(1'b0, 5);
        chk("long_done_rem", dut_o.remaining_q, 32'd8);
        chk("long_done_tail", 32'(o_tail), 32'd1);

        // Zero-size transfer stays idle
        do_reset();
        set_geom(16'd4, 16'd0);
        fifo_count = 16'd32;
        fd0 = fd_o + fd_l;
        pulse_fsync();
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= o_req | l_req;
        end
        chk("zero_no_req", 32'(seen), 32'd0);
        chk("zero_state_o", 32'(dut_o.state_q), 32'd0);
        chk("zero_state_l", 32'(dut_l.state_q), 32'd0);
        chk("zero_no_fd", 32'(fd_o + fd_l - fd0), 32'd0);

`ifdef WR_FRAME_CNT_EN
        // Three complete ONCE frames
        do_reset();
        set_geom(16'd4, 16'd64);
        fifo_count = 16'd32;
        for (int f = 0; f < 3; f++) begin
            sb_q.push_back('{len: 9'd16, tail: 1'b0});
            sb_q.push_back('{len: 9'd8, tail: 1'b1});
            pulse_fsync();
            serve(1'b0, 1);
            serve(1'b0, 1);
        end
        @(negedge clk);
        chk("frame_cnt", 32'(o_fcnt), 32'd3);
`endif

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/write_burst_len_gen.md
Name: write_burst_len_gen

Overview:
Write-side burst planner for the VDMA write path. It tracks how many AXI data words of the current frame (ONCE mode) or line (LINE mode) are still to be written to memory. It issues a burst request with a length to the AXI write issuer only when the write FIFO holds enough words. Requests are full NOR_BURST_LEN bursts, plus one shorter tail burst at the end of each frame or line.

Parameters:
NOR_BURST_LEN, 200, normal burst length in AXI beats
MODE, "ONCE", "ONCE" = one transfer per frame (vactive*hactive); "LINE" = one transfer per line (hactive)
AXI_DSIZE, 256, AXI data width in bits (power of two)
DSIZE, 24, pixel width in bits
LSIZE, 9, width of burst_len; must hold NOR_BURST_LEN

Ports:
clock  in  1  system clock
rst  in  1  synchronous reset, active-high
vactive  in  16  active lines per frame; quasi-static
hactive  in  16  active pixels per line; quasi-static
fsync  in  1  frame start pulse; restarts accounting
fifo_count  in  16  AXI words currently held in the write FIFO
burst_req  out  1  burst request to the write issuer
burst_len  out  LSIZE  beats in the requested burst; valid while burst_req=1
burst_ack  in  1  issuer accepted the request
burst_done  in  1  issuer finished the burst (level, may last several cycles)
tail_status  out  1  current or next burst is the tail
frame_done  out  1  1-cycle pulse when the last burst of the frame or line completes

Behaviour:
- Total words per transfer:
  - all_bits = hactive (LINE) or vactive*hactive (ONCE); 32-bit.
  - total = ceil(all_bits*DSIZE/AXI_DSIZE); use at least a 48-bit intermediate.
  - Recomputed every cycle through a 2-stage register pipeline. vactive and hactive must be stable for 3 cycles before fsync.
- remaining: 32-bit counter.
  - Reset value 0.
  - On fsync, remaining <= total.
- burst_done is edge-detected internally. Only its rising edge counts; one edge = one completion.
- FSM states IDLE, WAIT_DATA, REQ, BUSY. Reset state is IDLE.
- IDLE:
  - burst_req=0.
  - fsync -> WAIT_DATA. If total==0, stay IDLE.
- WAIT_DATA:
  - If remaining >= NOR_BURST_LEN and fifo_count >= NOR_BURST_LEN: latch len=NOR_BURST_LEN, go to REQ.
  - Else if 0 < remaining < NOR_BURST_LEN and fifo_count >= remaining: latch len=remaining, go to REQ.
- REQ:
  - burst_req=1 and burst_len is held stable until burst_ack.
  - A burst_ack sampled high with burst_req=1 moves to BUSY in the next cycle.
- BUSY:
  - burst_req=0.
  - On the burst_done rising edge: remaining <= remaining - len.
  - If the result is 0, pulse frame_done.
    - LINE mode: reload remaining <= total, go to WAIT_DATA.
    - ONCE mode: go to IDLE.
  - If the result is nonzero, go to WAIT_DATA.
- fsync in any state has priority over all other events:
  - remaining <= total, next state WAIT_DATA, burst_req drops next cycle.
  - A pending burst_done edge in the same cycle is discarded.
- A burst_done edge outside BUSY is ignored.
- burst_ack outside REQ is ignored.
- tail_status = registered (remaining < NOR_BURST_LEN and remaining != 0). Reset value 0.
- Reset values of all outputs: burst_req=0, burst_len=0, tail_status=0, frame_done=0.
- Latency:
  - fsync to remaining valid: 1 cycle.
  - FIFO condition met to burst_req high: 1 cycle.

Optional Feature:
Macro WR_FRAME_CNT_EN.
- Defined: adds output port frame_cnt [15:0]. It is cleared by rst and increments by 1 (wrapping at 0xFFFF) on every frame_done pulse.
- Undefined: no port, no counter logic.

Test Plan:
- ONCE, NOR_BURST_LEN=16, hactive=64, vactive=4, DSIZE=24, AXI_DSIZE=256 (total=24), fifo_count=32, fsync, ack and done each burst -> burst_len 16 with tail_status=0, then 8 with tail_status=1; frame_done pulses once; FSM ends in IDLE.
- LINE, NOR_BURST_LEN=16, hactive=100 (2400 bits, total=10), fifo_count=10 -> repeated 10-beat bursts with tail_status=1; frame_done after each; remaining reloads to 10.
- fifo_count held at 15 with remaining=24 -> no burst_req; raise to 16 -> burst_req next cycle with burst_len=16.
- fsync asserted in BUSY while burst_done rises in the same cycle -> remaining=24, state WAIT_DATA, no frame_done.
- burst_done held high for 5 cycles -> remaining decremented exactly once.
- hactive=0, fsync -> stays IDLE, burst_req=0, frame_done never pulses. With WR_FRAME_CNT_EN defined, after 3 completed frames frame_cnt=3.
